delay_timer_multi: RTL and testbench
====================================

# delay_timer_multi

Multi-channel, parametrised programmable delay timer: the successor to the team's LS7212-style single delay timer. Each channel drives an active-low output from its own trigger input. The four delay modes are selected by mode_b/mode_a: delayed operate, delayed release, dual delay and one-shot. New in this generation: delay width, tick prescaling and channel count are parameters, the one-shot can optionally be retriggered, and each channel reports busy status.

## Interface
- CHANNELS, 2: number of independent timer channels (≥1).
- WIDTH, 8: width of delay weight wb (≥1).
- PRESCALE, 1: clock cycles per delay tick (≥1); delay = wb × PRESCALE cycles.
- RETRIGGER, 0: 1 makes one-shot mode retriggerable.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb  input  WIDTH  delay weight, shared by all channels, sampled per channel at timing start.
- mode_a  input  1  mode select LSB, shared.
- mode_b  input  1  mode select MSB, shared.
- trigger  input  CHANNELS  asynchronous per-channel trigger levels.
- delay_out_n  output  CHANNELS  active-low timer outputs.
- busy  output  CHANNELS  1 while the channel is not in IDLE.

## Operation
- Each trigger bit passes through a 2-flop synchroniser (reset to 0), then a registered edge detector producing rise/fall.
- Per channel: FSM {IDLE, WAIT_ON, ON, WAIT_OFF}, a WIDTH-bit delay counter, a prescaler counter of width clog2(PRESCALE) (min 1), and a latched copy of wb.
- delay_out_n = 0 only in ON, and in WAIT_OFF of modes 01/10; otherwise 1. busy = (state != IDLE).
- Timing start: the prescaler clears, wb is latched and the counter loads it. On each prescaler wrap the counter decrements. Expiry is when the counter reaches 0.
- Mode 00, delayed operate:
  - IDLE→WAIT_ON on rise.
  - WAIT_ON→IDLE on fall (no output).
  - WAIT_ON→ON on expiry.
  - ON→IDLE on fall.
- Mode 01, delayed release:
  - IDLE→ON on rise.
  - ON→WAIT_OFF on fall (output stays low).
  - WAIT_OFF→ON on rise (delay cancelled).
  - WAIT_OFF→IDLE on expiry.
- Mode 10, dual delay: the mode 00 operate path combined with the mode 01 release path. WAIT_OFF keeps the output low.
- Mode 11, one-shot:
  - IDLE→ON on rise, starting timing; ON→IDLE on expiry.
  - Rise while in ON: ignored if RETRIGGER=0; reloads wb and restarts the prescaler if RETRIGGER=1.
  - Trigger level is otherwise ignored.
- wb = 0: the delay is zero.
  - Modes 00/10 go IDLE→ON directly on rise.
  - Modes 01/10 go ON→IDLE directly on fall.
  - Mode 11 produces no pulse; the channel stays IDLE.
- wb changes after timing start have no effect until the next start.
- Mode change: {mode_b,mode_a} is registered. When the registered value differs from its previous value, every channel goes to IDLE with delay_out_n=1 in the next cycle. Triggers are acted on again from the following cycle; a level already high is not treated as a rise.
- Simultaneous expiry and retrigger-rise in mode 11 with RETRIGGER=1: the reload wins, and the output stays low.
- Channels are fully independent apart from the shared wb and mode.

## Timing
- Reset asserted: immediately, and asynchronously, delay_out_n = all 1, busy = all 0, FSMs IDLE, counters and synchronisers 0.
- Reset release with trigger held high: the synchroniser ramps from 0, so one rise is detected; this is treated as a new trigger.
- Reset mid-delay aborts timing; no output glitch low.
- Latency, with a trigger edge first sampled at clock edge k:
  - Immediate transitions appear on delay_out_n/busy at edge k+3 (2 sync flops + edge register; output registered).
  - Delayed transitions appear at edge k+3+wb×PRESCALE.
- One-shot pulse width is exactly wb×PRESCALE cycles, or longer if retriggered.
- Trigger pulses shorter than 2 cycles may be missed; this is not required to be detected.

## Test plan
- Mode 00, CHANNELS=2, WIDTH=8, PRESCALE=4, wb=10: ch0 trigger high 100 cycles → delay_out_n[0] low at k+43, high at fall+3. ch0 trigger high only 20 cycles → no low output. ch1 unaffected throughout.
- Mode 01, wb=10, PRESCALE=4: output low at rise+3. Trigger falls → high 40 cycles after fall+3. Re-rise 20 cycles after fall → stays low continuously.
- Mode 10, wb=5, PRESCALE=1: rise → low at +8. Fall → high at fall+8. busy is 1 from rise+3 until release.
- Mode 11, wb=6, PRESCALE=2: rise → 12-cycle low pulse. Second rise 6 cycles in: RETRIGGER=0 keeps total 12; RETRIGGER=1 extends low to 18 cycles after the first assertion.
- Boundaries: wb=0 in mode 11 → no pulse, busy stays 0. wb changed mid-delay → original delay kept. wb=255, PRESCALE=1 → 255-cycle delay.
- Reset asserted mid-WAIT_ON and mid-ON → outputs high the same cycle. Mode switch during ON → all channels IDLE/high the next cycle.

Source files
------------

// File: rtl/delay_timer_multi_if.sv
// Bus bundle for delay_timer_multi: shared delay weight and mode select,
// per-channel trigger levels, and per-channel active-low outputs and busy flags.
interface delay_timer_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [WIDTH-1:0]    wb;
  logic                mode_a;
  logic                mode_b;
  logic [CHANNELS-1:0] trigger;
  logic [CHANNELS-1:0] delay_out_n;
  logic [CHANNELS-1:0] busy;

  modport master (
    output wb, mode_a, mode_b, trigger,
    input  delay_out_n, busy
  );

  modport slave (
    input  wb, mode_a, mode_b, trigger,
    output delay_out_n, busy
  );
endinterface

// File: rtl/delay_timer_multi.sv
// Multi-channel programmable delay timer. Each channel synchronises its
// trigger, detects edges and runs a four-state FSM (delayed operate, delayed
// release, dual delay, one-shot) timed by a prescaled down-counter.
module delay_timer_multi #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 1,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             reset,
  delay_timer_multi_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  localparam logic [1:0] M_OPER    = 2'b00;
  localparam logic [1:0] M_REL     = 2'b01;
  localparam logic [1:0] M_DUAL    = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ON  = 2'd1,
    ON       = 2'd2,
    WAIT_OFF = 2'd3
  } state_t;

  logic [1:0]          r_mode;
  logic [1:0]          r_mode_d;
  logic                w_mode_chg;
  logic                w_wb_zero;
  logic [CHANNELS-1:0] w_out_n;
  logic [CHANNELS-1:0] w_busy;

  // Register the shared mode and keep its previous value to spot changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= 2'b00;
      r_mode_d <= 2'b00;
    end else begin
      r_mode   <= {bus.mode_b, bus.mode_a};
      r_mode_d <= r_mode;
    end
  end

  assign w_mode_chg = (r_mode != r_mode_d);
  assign w_wb_zero  = (bus.wb == '0);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             r_sync1, r_sync2, r_sync2_d;
    logic             r_rise, r_fall;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_wb, w_wb_nxt;
    logic [PW-1:0]    r_pre, w_pre_nxt;
    logic             r_out_n, w_out_n_nxt;
    logic             r_busy;
    logic             w_start, w_timing, w_wrap, w_expire;

    // Two-flop synchroniser followed by a registered rise/fall detector.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_sync2_d <= 1'b0;
        r_rise    <= 1'b0;
        r_fall    <= 1'b0;
      end else begin
        r_sync1   <= bus.trigger[g];
        r_sync2   <= r_sync1;
        r_sync2_d <= r_sync2;
        r_rise    <= r_sync2 & ~r_sync2_d;
        r_fall    <= ~r_sync2 & r_sync2_d;
      end
    end

    // Counting happens while waiting, or while a one-shot pulse is active.
    assign w_timing = (r_state == WAIT_ON) || (r_state == WAIT_OFF) ||
                      ((r_state == ON) && (r_mode == M_ONESHOT));
    assign w_wrap   = (r_pre == PRE_LAST);
    // Expiry coincides with the counter stepping from 1 to 0.
    assign w_expire = w_timing && w_wrap && (r_cnt <= CNT_ONE);

    // Next-state, countdown and next-output logic for this channel.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pre_nxt   = r_pre;
      w_wb_nxt    = r_wb;
      w_start     = 1'b0;
      w_out_n_nxt = 1'b1;

      if (w_timing) begin
        if (w_wrap) begin
          w_pre_nxt = '0;
          w_cnt_nxt = (r_cnt != '0) ? (r_cnt - CNT_ONE) : r_cnt;
        end else begin
          w_pre_nxt = r_pre + PRE_ONE;
        end
      end else begin
        w_pre_nxt = r_pre;
      end

      if (w_mode_chg) begin
        w_state_nxt = IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_rise) begin
              case (r_mode)
                M_OPER, M_DUAL: begin
                  if (w_wb_zero) begin
                    w_state_nxt = ON;
                  end else begin
                    w_state_nxt = WAIT_ON;
                    w_start     = 1'b1;
                  end
                end
                M_REL:     w_state_nxt = ON;
                M_ONESHOT: begin
                  if (w_wb_zero) begin
                    w_state_nxt = IDLE;
                  end else begin
                    w_state_nxt = ON;
                    w_start     = 1'b1;
                  end
                end
                default:   w_state_nxt = IDLE;
              endcase
            end else begin
              w_state_nxt = IDLE;
            end
          end
          WAIT_ON: begin
            if (r_fall) begin
              w_state_nxt = IDLE;
            end else if (w_expire) begin
              w_state_nxt = ON;
            end else begin
              w_state_nxt = WAIT_ON;
            end
          end
          ON: begin
            case (r_mode)
              M_OPER: begin
                w_state_nxt = r_fall ? IDLE : ON;
              end
              M_REL, M_DUAL: begin
                if (r_fall) begin
                  if (w_wb_zero) begin
                    w_state_nxt = IDLE;
                  end else begin
                    w_state_nxt = WAIT_OFF;
                    w_start     = 1'b1;
                  end
                end else begin
                  w_state_nxt = ON;
                end
              end
              M_ONESHOT: begin
                // A retrigger reload takes priority over a same-cycle expiry.
                if (r_rise && (RETRIGGER != 0)) begin
                  w_state_nxt = w_wb_zero ? IDLE : ON;
                  w_start     = 1'b1;
                end else if (w_expire) begin
                  w_state_nxt = IDLE;
                end else begin
                  w_state_nxt = ON;
                end
              end
              default: w_state_nxt = IDLE;
            endcase
          end
          WAIT_OFF: begin
            if (r_rise) begin
              w_state_nxt = ON;
            end else if (w_expire) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = WAIT_OFF;
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end

      // Timing start: latch the weight, load the counter, clear the prescaler.
      if (w_start) begin
        w_wb_nxt  = bus.wb;
        w_cnt_nxt = bus.wb;
        w_pre_nxt = '0;
      end else begin
        w_wb_nxt  = r_wb;
      end

      case (w_state_nxt)
        ON:       w_out_n_nxt = 1'b0;
        WAIT_OFF: w_out_n_nxt = !((r_mode == M_REL) || (r_mode == M_DUAL));
        default:  w_out_n_nxt = 1'b1;
      endcase
    end

    // Channel state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_pre   <= '0;
        r_wb    <= '0;
        r_out_n <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pre   <= w_pre_nxt;
        r_wb    <= w_wb_nxt;
        r_out_n <= w_out_n_nxt;
        r_busy  <= (w_state_nxt != IDLE);
      end
    end

    assign w_out_n[g] = r_out_n;
    assign w_busy[g]  = r_busy;
  end

  assign bus.delay_out_n = w_out_n;
  assign bus.busy        = w_busy;
endmodule

// File: tb/tb_delay_timer_multi.sv
// Scoreboard bench for delay_timer_multi: four instances (different prescale /
// retrigger settings) share one stimulus; expected {delay_out_n, busy} per
// channel and cycle are queued when stimulus is driven and compared on negedge.
module tb_delay_timer_multi;
  localparam int ND = 4;
  localparam int PS [ND] = '{4, 1, 2, 2};
  localparam int RT [ND] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tb_wb;
  logic [1:0] tb_mode;
  logic [1:0] tb_trig;
  logic [1:0] w_out  [ND];
  logic [1:0] w_busy [ND];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int         cyc;
    int         d;
    int         ch;
    int         tid;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    delay_timer_multi_if #(.CHANNELS(2), .WIDTH(8)) u_if ();
    assign u_if.wb      = tb_wb;
    assign u_if.mode_a  = tb_mode[0];
    assign u_if.mode_b  = tb_mode[1];
    assign u_if.trigger = tb_trig;
    assign w_out[g]     = u_if.delay_out_n;
    assign w_busy[g]    = u_if.busy;
    delay_timer_multi #(.CHANNELS(2), .WIDTH(8), .PRESCALE(PS[g]), .RETRIGGER(RT[g])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
    );
  end

  // Free-running clock.
  always #5 clk = ~clk;

  // Count rising edges; sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Queue expectation {out_n, busy} for cycles from..to, kept sorted by cycle.
  task automatic push_exp(input int tid, input int d, input int ch, input int from,
                          input int to, input logic o, input logic b);
    exp_t e;
    int   idx;
    for (int c = from; c <= to; c++) begin
      e.cyc = c; e.d = d; e.ch = ch; e.tid = tid; e.val = {o, b};
      idx = sb.size();
      while (idx > 0 && sb[idx-1].cyc > c) idx--;
      sb.insert(idx, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop and compare every expectation due at this cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("t%0d_d%0d_ch%0d_c%0d", e.tid, e.d, e.ch, e.cyc),
               {30'd0, w_out[e.d][e.ch], w_busy[e.d][e.ch]}, {30'd0, e.val});
    end
  end

  initial begin
    int c;
    reset = 1'b1; tb_trig = 2'b00; tb_wb = 8'd10; tb_mode = 2'b00;
    #1;
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("reset_d%0d", d), {28'd0, w_out[d], w_busy[d]}, 32'hC);
    tick(3);
    reset = 1'b0;
    tick(5);

    // T1: mode 00, P=4, wb=10, trigger held 100 cycles; ch1 untouched.
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(1, 0, 0, c+1,   c+3,   1'b1, 1'b0);
    push_exp(1, 0, 0, c+4,   c+43,  1'b1, 1'b1);
    push_exp(1, 0, 0, c+44,  c+103, 1'b0, 1'b1);
    push_exp(1, 0, 0, c+104, c+110, 1'b1, 1'b0);
    push_exp(1, 0, 1, c+1,   c+110, 1'b1, 1'b0);
    tick(100); tb_trig[0] = 1'b0; tick(15);

    // T2: mode 00, trigger only 20 cycles: never low.
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(2, 0, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(2, 0, 0, c+4,  c+23, 1'b1, 1'b1);
    push_exp(2, 0, 0, c+24, c+40, 1'b1, 1'b0);
    tick(20); tb_trig[0] = 1'b0; tick(25);

    // T3: mode 01, P=4, wb=10: release delay, then cancelled release.
    tb_mode = 2'b01; tick(5);
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(3, 0, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(3, 0, 0, c+4,  c+73, 1'b0, 1'b1);
    push_exp(3, 0, 0, c+74, c+80, 1'b1, 1'b0);
    tick(30); tb_trig[0] = 1'b0; tick(55);
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(4, 0, 0, c+1,   c+3,   1'b1, 1'b0);
    push_exp(4, 0, 0, c+4,   c+103, 1'b0, 1'b1);
    push_exp(4, 0, 0, c+104, c+110, 1'b1, 1'b0);
    tick(20); tb_trig[0] = 1'b0; tick(20); tb_trig[0] = 1'b1;
    tick(20); tb_trig[0] = 1'b0; tick(55);

    // T5: mode 10, P=1, wb=5; then wb=0 (immediate on and off).
    tb_mode = 2'b10; tb_wb = 8'd5; tick(5);
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(5, 1, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(5, 1, 0, c+4,  c+8,  1'b1, 1'b1);
    push_exp(5, 1, 0, c+9,  c+38, 1'b0, 1'b1);
    push_exp(5, 1, 0, c+39, c+45, 1'b1, 1'b0);
    tick(30); tb_trig[0] = 1'b0; tick(20);
    tb_wb = 8'd0;
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(6, 1, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(6, 1, 0, c+4,  c+13, 1'b0, 1'b1);
    push_exp(6, 1, 0, c+14, c+20, 1'b1, 1'b0);
    tick(10); tb_trig[0] = 1'b0; tick(15);

    // T7: mode 11, P=2, wb=6, second rise 6 cycles into the pulse.
    tb_mode = 2'b11; tb_wb = 8'd6; tick(5);
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(7, 2, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(7, 2, 0, c+4,  c+15, 1'b0, 1'b1);
    push_exp(7, 2, 0, c+16, c+30, 1'b1, 1'b0);
    push_exp(8, 3, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(8, 3, 0, c+4,  c+21, 1'b0, 1'b1);
    push_exp(8, 3, 0, c+22, c+30, 1'b1, 1'b0);
    tick(3); tb_trig[0] = 1'b0; tick(3); tb_trig[0] = 1'b1;
    tick(6); tb_trig[0] = 1'b0; tick(25);

    // T9: mode 11 with wb=0: no pulse, never busy.
    tb_wb = 8'd0;
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(9, 2, 0, c+1, c+15, 1'b1, 1'b0);
    push_exp(9, 3, 0, c+1, c+15, 1'b1, 1'b0);
    tick(8); tb_trig[0] = 1'b0; tick(10);

    // T10: mode 00, P=1, wb=20 changed to 3 mid-delay: 20 still applies.
    tb_mode = 2'b00; tb_wb = 8'd20; tick(5);
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(10, 1, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(10, 1, 0, c+4,  c+23, 1'b1, 1'b1);
    push_exp(10, 1, 0, c+24, c+43, 1'b0, 1'b1);
    push_exp(10, 1, 0, c+44, c+50, 1'b1, 1'b0);
    tick(8); tb_wb = 8'd3; tick(32); tb_trig[0] = 1'b0; tick(15);

    // T11: mode 00, P=1, wb=255: full-range delay; ch1 idle.
    tb_wb = 8'd255;
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(11, 1, 0, c+4,   c+258, 1'b1, 1'b1);
    push_exp(11, 1, 0, c+259, c+273, 1'b0, 1'b1);
    push_exp(11, 1, 0, c+274, c+280, 1'b1, 1'b0);
    push_exp(11, 1, 1, c+1,   c+280, 1'b1, 1'b0);
    tick(270); tb_trig[0] = 1'b0; tick(15);

    // T12: mode switch while both channels ON: all idle next cycle, no re-arm.
    tb_wb = 8'd2;
    c = cyc; tb_trig = 2'b11;
    for (int ch = 0; ch < 2; ch++) begin
      push_exp(12, 1, ch, c+4,  c+5,  1'b1, 1'b1);
      push_exp(12, 1, ch, c+6,  c+16, 1'b0, 1'b1);
      push_exp(12, 1, ch, c+17, c+30, 1'b1, 1'b0);
    end
    tick(15); tb_mode = 2'b01; tick(20); tb_trig = 2'b00; tick(5);

    // T13: reset mid-WAIT_ON (P=4) and mid-ON (P=1), then release with trigger high.
    tb_mode = 2'b00; tb_wb = 8'd10; tick(5);
    c = cyc; tb_trig[0] = 1'b1;
    push_exp(13, 0, 0, c+4,  c+19, 1'b1, 1'b1);
    push_exp(13, 1, 0, c+4,  c+13, 1'b1, 1'b1);
    push_exp(13, 1, 0, c+14, c+19, 1'b0, 1'b1);
    tick(20);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("rst_mid_d%0d", d), {28'd0, w_out[d], w_busy[d]}, 32'hC);
    tick(3);
    check_eq("rst_hold_d1", {28'd0, w_out[1], w_busy[1]}, 32'hC);
    c = cyc; reset = 1'b0;
    push_exp(14, 1, 0, c+1,  c+3,  1'b1, 1'b0);
    push_exp(14, 1, 0, c+4,  c+13, 1'b1, 1'b1);
    push_exp(14, 1, 0, c+14, c+20, 1'b0, 1'b1);
    tick(20); tb_trig[0] = 1'b0; tick(10);

    check_eq("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
